// File: rtl/eth_dst_mac_filter.sv
// eth_dst_mac_filter
// Destination-MAC filter on an 8-bit AXI-Stream path. The first six bytes of
// each frame are held back while the destination address is captured. The
// frame is then either replayed and passed through, or silently consumed.
// A frame is forwarded if its destination is the local MAC, the broadcast
// address, or promiscuous mode is set. Frames that end before a complete
// destination address plus at least one more byte are dropped as runts.
// Optional build macro ETH_DST_MAC_FILTER_STATS_EN adds saturating
// forward/drop/runt counters.
module eth_dst_mac_filter #(
  parameter int HDR_BYTES = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  // frames from the MAC RX FIFO; tuser on the tlast beat marks a bad frame
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  // filtered frames
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic        tx_tuser,
  // configuration, sampled on the sixth header byte
  input  logic [47:0] cfg_local_mac,
  input  logic        cfg_promisc,
  output logic        drop_pulse,
  output logic        runt_pulse
`ifdef ETH_DST_MAC_FILTER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_fwd_count,
  output logic [CNT_WIDTH-1:0] stat_drop_count,
  output logic [CNT_WIDTH-1:0] stat_runt_count
`endif
);

  // The header buffer and counters below are sized for a 6-byte MAC address.
  generate
    if (HDR_BYTES != 6 || CNT_WIDTH < 1) begin : g_param_check
      $fatal(1, "eth_dst_mac_filter: HDR_BYTES must be 6 and CNT_WIDTH >= 1");
    end
  endgenerate

  localparam logic [1:0] HDR   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] PASS  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]  state;
  logic [2:0]  cnt;          // header byte index in HDR, replay index in FLUSH
  logic [7:0]  hdr [0:5];
  logic        rx_hs;
  logic        hdr_last;
  logic [47:0] dst_mac;
  logic        addr_match;
  logic        fwd_decide;

  assign rx_hs    = rx_tvalid & rx_tready;
  assign hdr_last = (cnt == 3'd5);
  // The sixth byte is still on the bus when the decision is made.
  assign dst_mac  = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], rx_tdata};
  assign addr_match = cfg_promisc || (dst_mac == cfg_local_mac) || (&dst_mac);
  assign fwd_decide = (state == HDR) && rx_hs && !rx_tlast && hdr_last && addr_match;

  // Handshake and data steering for each state; outputs fall to idle values
  // as soon as reset forces the state back to HDR.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    rx_tready = 1'b0;
    tx_tvalid = 1'b0;
    tx_tdata  = 8'h00;
    tx_tlast  = 1'b0;
    tx_tuser  = 1'b0;
    case (state)
      HDR: begin
        rx_tready = 1'b1;
      end
      FLUSH: begin
        tx_tvalid = 1'b1;
        tx_tdata  = hdr[cnt];
      end
      PASS: begin
        tx_tvalid = rx_tvalid;
        rx_tready = tx_tready;
        tx_tdata  = rx_tdata;
        tx_tlast  = rx_tlast;
        tx_tuser  = rx_tuser;
      end
      default: begin
        rx_tready = 1'b1;
      end
    endcase
  end

  // Capture destination-address bytes as they are accepted.
  // NOTE: the header buffer has no reset; it is always rewritten before it is
  // replayed, so clearing it would only cost reset routing.
  always_ff @(posedge clk) begin
    if (state == HDR && rx_hs) begin
      hdr[cnt] <= rx_tdata;
    end
  end

  // Frame-level FSM: collect header, decide, replay header, pass or drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HDR;
      cnt        <= 3'd0;
      drop_pulse <= 1'b0;
      runt_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      runt_pulse <= 1'b0;
      case (state)
        HDR: begin
          if (rx_hs) begin
            if (rx_tlast) begin
              drop_pulse <= 1'b1;
              runt_pulse <= 1'b1;
              cnt        <= 3'd0;
            end else if (hdr_last) begin
              cnt <= 3'd0;
              if (addr_match) begin
                state <= FLUSH;
              end else begin
                state      <= DROP;
                drop_pulse <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        FLUSH: begin
          if (tx_tready) begin
            if (hdr_last) begin
              state <= PASS;
              cnt   <= 3'd0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        PASS: begin
          if (rx_hs && rx_tlast) begin
            state <= HDR;
          end
        end
        default: begin
          if (rx_hs && rx_tlast) begin
            state <= HDR;
          end
        end
      endcase
    end
  end

`ifdef ETH_DST_MAC_FILTER_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fwd_count  <= '0;
      stat_drop_count <= '0;
      stat_runt_count <= '0;
    end else begin
      if (fwd_decide && !(&stat_fwd_count)) begin
        stat_fwd_count <= stat_fwd_count + 1'b1;
      end
      if (drop_pulse && !(&stat_drop_count)) begin
        stat_drop_count <= stat_drop_count + 1'b1;
      end
      if (runt_pulse && !(&stat_runt_count)) begin
        stat_runt_count <= stat_runt_count + 1'b1;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = fwd_decide;
`endif

endmodule

// File: tb/tb_eth_dst_mac_filter.sv
// Scoreboard bench for eth_dst_mac_filter: the driver pushes every byte it
// expects on tx, and an independent monitor pops and compares on each tx
// handshake. Pulses are tallied by the monitor and compared at checkpoints.
module tb_eth_dst_mac_filter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic        rx_tlast;
  logic        rx_tuser;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        tx_tlast;
  logic        tx_tuser;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc;
  logic        drop_pulse;
  logic        runt_pulse;
`ifdef ETH_DST_MAC_FILTER_STATS_EN
  logic [31:0] stat_fwd_count;
  logic [31:0] stat_drop_count;
  logic [31:0] stat_runt_count;
`endif

  always #5 clk = ~clk;

  eth_dst_mac_filter #(.HDR_BYTES(6), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc),
    .drop_pulse(drop_pulse), .runt_pulse(runt_pulse)
`ifdef ETH_DST_MAC_FILTER_STATS_EN
    ,
    .stat_fwd_count(stat_fwd_count), .stat_drop_count(stat_drop_count),
    .stat_runt_count(stat_runt_count)
`endif
  );

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MISC_MAC  = 48'h11_22_33_44_55_66;

  logic [9:0] exp_q[$];            // {tuser, tlast, tdata}
  int checks = 0;
  int errors = 0;
  int obs_drop = 0, obs_runt = 0;  // pulse cycles seen by the monitor
  int exp_drop = 0, exp_runt = 0;  // pulses the stimulus should cause
  int st_fwd = 0, st_drop = 0, st_runt = 0;  // tallies since last reset
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [47:0] dst, input int k, input int seed);
    if (k < 6) return dst[47 - 8*k -: 8];
    return 8'(k + seed);
  endfunction

  // tx ready generator: always ready, or a fair coin per cycle
  always @(posedge clk) begin
    #1;
    tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pop, stall-stability check, pulse tallies
  logic       stall_prev = 1'b0;
  logic [9:0] stall_beat = '0;
  logic [9:0] exp_beat;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("tx_hold", {tx_tvalid, tx_tuser, tx_tlast, tx_tdata}, {1'b1, stall_beat});
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got beat %0h expected none", {tx_tuser, tx_tlast, tx_tdata});
        end else begin
          exp_beat = exp_q.pop_front();
          check("tx_beat", {tx_tuser, tx_tlast, tx_tdata}, exp_beat);
        end
      end
      stall_prev = tx_tvalid && !tx_tready;
      stall_beat = {tx_tuser, tx_tlast, tx_tdata};
      if (drop_pulse) obs_drop++;
      if (runt_pulse) begin
        obs_runt++;
        check("runt_implies_drop", drop_pulse, 1);
      end
    end
  end

  // Send one frame. fwd is the hand-decided outcome for non-runt frames.
  // abort_at >= 0 asserts reset while that byte is on the bus.
  task automatic send_frame(input logic [47:0] dst, input int len, input logic user_last,
                            input bit fwd, input int abort_at, input int seed,
                            output int stalls);
    bit hs;
    int budget;
    stalls = 0;
    if (len < 7) begin
      exp_drop++; exp_runt++; st_drop++; st_runt++;
    end else if (fwd) begin
      st_fwd++;
    end else begin
      exp_drop++; st_drop++;
    end
    for (int k = 0; k < len; k++) begin
      rx_tdata  = frame_byte(dst, k, seed);
      rx_tlast  = (k == len - 1);
      rx_tuser  = user_last && (k == len - 1);
      rx_tvalid = 1'b1;
      if (k == abort_at) begin
        #1;
        check("pre_reset_tvalid", tx_tvalid, 1);
        reset_n = 1'b0;
        #1;
        check("reset_tvalid", tx_tvalid, 0);
        check("reset_tdata", tx_tdata, 0);
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
        return;
      end
      if (fwd && len >= 7) exp_q.push_back({rx_tuser, rx_tlast, rx_tdata});
      budget = 0;
      forever begin
        @(negedge clk);
        hs = rx_tready;
        if (!hs) stalls++;
        @(posedge clk);
        #1;
        if (hs) break;
        budget++;
        if (budget > 1000) begin
          checks++;
          errors++;
          $display("FAIL rx_handshake_timeout: got no ready expected ready within 1000 cycles");
          break;
        end
      end
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  // Drain the scoreboard (bounded), then compare pulse tallies.
  task automatic settle(input string name);
    int n = 0;
    rand_ready = 1'b0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_drop_pulses"}, obs_drop, exp_drop);
    check({name, "_runt_pulses"}, obs_runt, exp_runt);
  endtask

  task automatic check_stats(input string name);
`ifdef ETH_DST_MAC_FILTER_STATS_EN
    check({name, "_stat_fwd"}, stat_fwd_count, st_fwd);
    check({name, "_stat_drop"}, stat_drop_count, st_drop);
    check({name, "_stat_runt"}, stat_runt_count, st_runt);
`else
    check({name, "_no_stats_drop_pulses"}, obs_drop, exp_drop);
`endif
  endtask

  initial begin
    int stalls;
    reset_n       = 1'b0;
    rx_tdata      = 8'h00;
    rx_tvalid     = 1'b0;
    rx_tlast      = 1'b0;
    rx_tuser      = 1'b0;
    tx_tready     = 1'b1;
    cfg_local_mac = LOCAL_MAC;
    cfg_promisc   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_tvalid", tx_tvalid, 0);
    check("rst_tdata", {tx_tlast, tx_tuser, tx_tdata}, 0);
    check("rst_pulses", {drop_pulse, runt_pulse}, 0);
    check("rst_rx_ready", rx_tready, 1);
    @(posedge clk);
    #1;

    // T1 unicast match, 64 bytes
    send_frame(LOCAL_MAC, 64, 1'b0, 1'b1, -1, 8'h10, stalls);
    settle("t1_unicast");
    // T2 broadcast, 60 bytes
    send_frame(BCAST_MAC, 60, 1'b0, 1'b1, -1, 8'h20, stalls);
    settle("t2_bcast");
    // T2 mismatch: dropped, rx never stalls
    send_frame(OTHER_MAC, 60, 1'b0, 1'b0, -1, 8'h30, stalls);
    check("t2_mismatch_no_stall", stalls, 0);
    settle("t2_mismatch");
    // T3 runt (4 bytes) followed back-to-back by a good frame
    send_frame(LOCAL_MAC, 4, 1'b0, 1'b0, -1, 0, stalls);
    check("t3_runt_no_stall", stalls, 0);
    send_frame(LOCAL_MAC, 64, 1'b0, 1'b1, -1, 8'h40, stalls);
    settle("t3_runt");
    check_stats("t3");
    // Boundary: exactly 6 bytes is a runt, 7 bytes is the shortest forwarded frame
    send_frame(LOCAL_MAC, 6, 1'b0, 1'b0, -1, 0, stalls);
    send_frame(LOCAL_MAC, 7, 1'b1, 1'b1, -1, 8'h50, stalls);
    settle("bound_6_7");
    // T4 random backpressure over 100 bytes, tuser on last beat
    rand_ready = 1'b1;
    send_frame(LOCAL_MAC, 100, 1'b1, 1'b1, -1, 8'h60, stalls);
    settle("t4_backpressure");
    check_stats("t4");
    // T5 reset during byte 30 of PASS, then a fresh frame
    send_frame(LOCAL_MAC, 64, 1'b0, 1'b1, 29, 8'h70, stalls);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    st_fwd = 0; st_drop = 0; st_runt = 0;
    check_stats("t5_after_reset");
    send_frame(LOCAL_MAC, 64, 1'b0, 1'b1, -1, 8'h80, stalls);
    settle("t5_reset");
    // T6 promiscuous, three back-to-back frames with mixed destinations
    cfg_promisc = 1'b1;
    send_frame(LOCAL_MAC, 64, 1'b0, 1'b1, -1, 8'h90, stalls);
    send_frame(OTHER_MAC, 64, 1'b0, 1'b1, -1, 8'hA0, stalls);
    send_frame(MISC_MAC, 64, 1'b1, 1'b1, -1, 8'hB0, stalls);
    settle("t6_promisc");
    cfg_promisc = 1'b0;
    check_stats("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound on the whole run
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1, "timeout");
  end

endmodule
